// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: PC generation with prioritised redirects, fetch fault
// check and a DEPTH-deep prefetch FIFO. Optional zero-latency path: FETCH_BYPASS_EN.
module fetch_queue_stage #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] ADDR_LO    = 32'h0000_3000,
  parameter logic [31:0] ADDR_HI    = 32'h0000_4ffc
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IntReq,
  input  logic        Eret,
  input  logic [31:0] EPC,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] ImAddr,
  input  logic [31:0] ImData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] InstrFD,
  output logic [31:0] PCFD,
  output logic [31:0] PC4FD,
  output logic [4:0]  ExcCodeFD,
  output logic        Full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [4:0]    exc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          redirect_any;
  logic [31:0]   target;
  logic          fault;
  logic [31:0]   fetch_instr;
  logic [4:0]    fetch_exc;
  logic          stored_valid, bypass_show, bypass_take;
  logic          pop, push, write;

  always_comb begin
    redirect_any = Eret | IntReq | Redirect;
    target       = Eret ? EPC : (IntReq ? HANDLER_PC : RedirectPC);
    fault        = (pc[1:0] != 2'b00) || (pc < ADDR_LO) || (pc > ADDR_HI);
    fetch_instr  = fault ? 32'h0 : ImData;
    fetch_exc    = fault ? 5'd4 : 5'd0;
    stored_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
    bypass_show  = !stored_valid && !redirect_any;
`else
    bypass_show  = 1'b0;
`endif
    bypass_take  = bypass_show && OutReady;
    pop          = stored_valid && OutReady && !redirect_any;
    push         = !redirect_any && ((count < DEPTH_C) || pop);
    // A bypassed fetch advances the PC but never occupies a slot.
    write        = push && !bypass_take;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
        exc_mem[i]   <= '0;
      end
    end else if (redirect_any) begin
      pc     <= target;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) pc <= pc + 32'd4;
      if (write) begin
        pc_mem[wr_ptr]    <= pc;
        instr_mem[wr_ptr] <= fetch_instr;
        exc_mem[wr_ptr]   <= fetch_exc;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(write) - (AW+1)'(pop);
    end
  end

  always_comb begin
    ImAddr   = pc;
    Full     = (count == DEPTH_C);
    OutValid = stored_valid || bypass_show;
    if (bypass_show) begin
      PCFD      = pc;
      InstrFD   = fetch_instr;
      ExcCodeFD = fetch_exc;
    end else begin
      PCFD      = pc_mem[rd_ptr];
      InstrFD   = instr_mem[rd_ptr];
      ExcCodeFD = exc_mem[rd_ptr];
    end
    PC4FD = PCFD + 32'd4;
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage; expectations adapt when FETCH_BYPASS_EN is defined.
module tb_fetch_queue_stage;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, IntReq, Eret, Redirect, OutReady;
  logic [31:0] EPC, RedirectPC, ImAddr, ImData, InstrFD, PCFD, PC4FD;
  logic        OutValid, Full;
  logic [4:0]  ExcCodeFD;

  int tests = 0;
  int fails = 0;

  fetch_queue_stage dut (
    .Clk(Clk), .Reset(Reset), .IntReq(IntReq), .Eret(Eret), .EPC(EPC),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .ImAddr(ImAddr), .ImData(ImData),
    .OutValid(OutValid), .OutReady(OutReady), .InstrFD(InstrFD), .PCFD(PCFD),
    .PC4FD(PC4FD), .ExcCodeFD(ExcCodeFD), .Full(Full)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hdead_beef;
  endfunction

  assign ImData = mem_word(ImAddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic fault);
    check({tag, "_valid"}, 32'(OutValid), 32'd1);
    check({tag, "_pc"}, PCFD, pc);
    check({tag, "_pc4"}, PC4FD, pc + 32'd4);
    check({tag, "_instr"}, InstrFD, fault ? 32'h0 : mem_word(pc));
    check({tag, "_exc"}, 32'(ExcCodeFD), fault ? 32'd4 : 32'd0);
  endtask

  initial begin
    Reset = 1'b0; IntReq = 1'b0; Eret = 1'b0; Redirect = 1'b0; OutReady = 1'b0;
    EPC = '0; RedirectPC = '0;
    step(); step();
    check("rst_valid", 32'(OutValid), 32'd0);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_pcfd", PCFD, 32'h0);
    check("rst_instr", InstrFD, 32'h0);
    check("rst_imaddr", ImAddr, 32'h3000);

    // Release reset with decode ready: continuous stream of sequential heads.
    Reset = 1'b1; OutReady = 1'b1;
    #1;
    check("release_valid", 32'(OutValid), 32'(BYP));
`ifdef FETCH_BYPASS_EN
    check("release_byp_pc", PCFD, 32'h3000);
`endif
    for (int k = 1; k <= 4; k++) begin
      step();
      check_head($sformatf("seq%0d", k), 32'h3000 + 32'(4 * (k - 1 + BYP)), 1'b0);
`ifdef FETCH_BYPASS_EN
      check($sformatf("seq%0d_count", k), 32'(dut.count), 32'd0);
`endif
    end

    // Restart at 0x3000 and fill with decode stalled.
    Redirect = 1'b1; RedirectPC = 32'h3000;
    step();
    Redirect = 1'b0; OutReady = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) check("fill3_full", 32'(Full), 32'd0);
      if (k == 4) check("fill4_full", 32'(Full), 32'd1);
      if (k == 4) check("fill4_imaddr", ImAddr, 32'h3010);
    end
    check("frozen_full", 32'(Full), 32'd1);
    check("frozen_imaddr", ImAddr, 32'h3010);
    OutReady = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      check_head($sformatf("drain%0d", j), 32'h3000 + 32'(4 * j), 1'b0);
      step();
    end
    OutReady = 1'b0;
    #1;
    check("refull_full", 32'(Full), 32'd1);

    // Interrupt beats branch; full queue flushed even with decode ready.
    Redirect = 1'b1; RedirectPC = 32'h3400; IntReq = 1'b1; OutReady = 1'b1;
    step();
    Redirect = 1'b0; IntReq = 1'b0; OutReady = 1'b0;
    #1;
    check("int_flush_valid", 32'(OutValid), 32'(BYP));
    check("int_flush_full", 32'(Full), 32'd0);
    check("int_imaddr", ImAddr, 32'h4180);
    step();
    check_head("int_head", 32'h4180, 1'b0);

    // Eret beats interrupt; misaligned EPC faults and stays faulting.
    Eret = 1'b1; EPC = 32'h3002; IntReq = 1'b1;
    step();
    Eret = 1'b0; IntReq = 1'b0;
    step();
    check_head("eret_head", 32'h3002, 1'b1);
    OutReady = 1'b1;
    step();
    check_head("eret_next", 32'h3006, 1'b1);

    // Run sequentially past the top of the legal range.
    OutReady = 1'b0; Redirect = 1'b1; RedirectPC = 32'h4ff8;
    step();
    Redirect = 1'b0;
    step();
    check_head("hi0", 32'h4ff8, 1'b0);
    OutReady = 1'b1;
    step();
    check_head("hi1", 32'h4ffc, 1'b0);
    step();
    check_head("hi2", 32'h5000, 1'b1);

    // Mid-operation reset discards the queue.
    Reset = 1'b0;
    step();
    Reset = 1'b1; OutReady = 1'b0;
    #1;
    check("rst2_imaddr", ImAddr, 32'h3000);
    check("rst2_full", 32'(Full), 32'd0);
    check("rst2_valid", 32'(OutValid), 32'(BYP));
    check("rst2_pcfd", PCFD, BYP ? 32'h3000 : 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
